// File: rtl/timer_responder.sv
// Memory-mapped countdown timer slave for the MIPS data bus: CTRL/PRESET/COUNT registers
// and a four-state countdown FSM. Optional macro TIMER_IRQ_EN enables irq_flag, CTRL.IM and irq.
module timer_responder #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    addr,
    input  logic          we,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          irq,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

`ifdef TIMER_IRQ_EN
    localparam logic [3:0] CTRL_MASK = 4'hF;
`else
    localparam logic [3:0] CTRL_MASK = 4'h7;
`endif
    localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

    state_t        state, state_n;
    logic [3:0]    ctrl;
    logic [DW-1:0] preset;
    logic [DW-1:0] count, count_n;
    logic          en_clr;
    logic          wr_ctrl, wr_preset;
    logic [3:0]    ctrl_wval;
    logic          en_look;
    logic          mode_auto;

    assign wr_ctrl   = we && (addr == 2'd0);
    assign wr_preset = we && (addr == 2'd1);
    assign ctrl_wval = wdata[3:0] & CTRL_MASK;
    assign mode_auto = (ctrl[2:1] == 2'b01);
    // IDLE looks at the EN value being written this edge so LOAD follows the enabling write directly
    assign en_look   = wr_ctrl ? ctrl_wval[0] : ctrl[0];
    assign dbg_state = state;

`ifdef TIMER_IRQ_EN
    logic irq_flag;
    logic flag_set, flag_clr_fsm;
`endif

    always_comb begin
        state_n = state;
        count_n = count;
        en_clr  = 1'b0;
`ifdef TIMER_IRQ_EN
        flag_set     = 1'b0;
        flag_clr_fsm = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (en_look) state_n = LOAD;
            end
            LOAD: begin
                count_n = preset;
                state_n = CNT;
            end
            CNT: begin
                if (!ctrl[0]) begin
                    state_n = IDLE;
                end else if (count > ONE) begin
                    count_n = count - ONE;
                end else begin
                    count_n = '0;
                    state_n = INT;
`ifdef TIMER_IRQ_EN
                    flag_set = 1'b1;
`endif
                end
            end
            INT: begin
                if (mode_auto) begin
`ifdef TIMER_IRQ_EN
                    flag_clr_fsm = 1'b1;
`endif
                end else begin
                    en_clr = 1'b1;
                end
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            preset <= '0;
            ctrl   <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
            if (wr_preset) preset <= wdata;
            // a bus write to CTRL overrides the one-shot EN clear
            if (wr_ctrl) ctrl <= ctrl_wval;
            else if (en_clr) ctrl[0] <= 1'b0;
        end
    end

`ifdef TIMER_IRQ_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_flag <= 1'b0;
        end else if (flag_set) begin
            irq_flag <= 1'b1;
        end else if (flag_clr_fsm || wr_ctrl || wr_preset) begin
            irq_flag <= 1'b0;
        end
    end

    assign irq = irq_flag & ctrl[3];
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        case (addr)
            2'd0:    rdata = {{(DW-4){1'b0}}, ctrl};
            2'd1:    rdata = preset;
            2'd2:    rdata = count;
            default: rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_timer_responder.sv
// Directed scoreboard bench for timer_responder: the driver queues expected bus reads,
// a monitor process compares rdata/irq/state whenever a read is presented.
module tb_timer_responder;

    localparam int DW = 32;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_CNT  = 2'd2;
    localparam logic [1:0] S_INT  = 2'd3;
`ifdef TIMER_IRQ_EN
    localparam logic I = 1'b1;
`else
    localparam logic I = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    addr = 2'd0;
    logic          we = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] rdata;
    logic          irq;
    logic [1:0]    dbg_state;

    timer_responder #(.DW(DW)) dut (
        .clk(clk), .reset(reset), .addr(addr), .we(we), .wdata(wdata),
        .rdata(rdata), .irq(irq), .dbg_state(dbg_state)
    );

    // clock / watchdog
    always #50 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // scoreboard
    typedef struct {
        logic [DW-1:0] data;
        logic          irq;
        logic [1:0]    st;
        bit            use_st;
        string         name;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    event sample_ev;

    initial begin
        forever begin
            @(sample_ev);
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL monitor_underflow: read presented with no expectation queued");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (rdata !== e.data || irq !== e.irq || (e.use_st && dbg_state !== e.st)) begin
                    bad++;
                    $display("FAIL %s: got rdata=0x%0h irq=%b state=%0d, expected rdata=0x%0h irq=%b state=%0d%s",
                             e.name, rdata, irq, dbg_state, e.data, e.irq, e.st,
                             e.use_st ? "" : " (state not checked)");
                end
            end
        end
    end

    // driver tasks
    function automatic logic [DW-1:0] cm(input logic [DW-1:0] v);
        return v & (I ? 32'hF : 32'h7);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [DW-1:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
    endtask

    task automatic chk(input logic [1:0] a, input logic [DW-1:0] d, input logic i,
                       input logic [1:0] s, input bit us, input string n);
        exp_t e;
        addr = a;
        #1;
        e.data   = d;
        e.irq    = i;
        e.st     = s;
        e.use_st = us;
        e.name   = n;
        exp_q.push_back(e);
        -> sample_ev;
        #1;
    endtask

    task automatic ch(input logic [1:0] a, input logic [DW-1:0] d, input logic i, input string n);
        chk(a, d, i, S_IDLE, 1'b0, n);
    endtask

    task automatic chs(input logic [1:0] a, input logic [DW-1:0] d, input logic i,
                       input logic [1:0] s, input string n);
        chk(a, d, i, s, 1'b1, n);
    endtask

    // auto-reload expectations, one per edge starting at the enabling write
    logic [1:0]    ar_st  [11] = '{S_LOAD, S_CNT, S_CNT, S_CNT, S_INT, S_IDLE,
                                   S_LOAD, S_CNT, S_CNT, S_CNT, S_INT};
    logic [DW-1:0] ar_cnt [11] = '{0, 3, 2, 1, 0, 0, 0, 3, 2, 1, 0};

    initial begin
        // reset held: everything reads zero
        #20;
        chs(2'd0, 0, 1'b0, S_IDLE, "rst_ctrl");
        ch(2'd1, 0, 1'b0, "rst_preset");
        ch(2'd2, 0, 1'b0, "rst_count");
        ch(2'd3, 0, 1'b0, "rst_rsvd");
        reset = 1'b0;
        tick();
        chs(2'd2, 0, 1'b0, S_IDLE, "post_rst_count");

        // one-shot, PRESET=5, CTRL=0x9
        wr(2'd1, 5);
        ch(2'd1, 5, 1'b0, "os_preset");
        wr(2'd0, 32'h9);
        chs(2'd2, 0, 1'b0, S_LOAD, "os_load");
        for (int k = 0; k < 5; k++) begin
            tick();
            chs(2'd2, 5 - k, 1'b0, S_CNT, $sformatf("os_cnt%0d", 5 - k));
        end
        tick();
        chs(2'd2, 0, I, S_INT, "os_int");
        ch(2'd0, cm(32'h9), I, "os_ctrl_in_int");
        tick();
        chs(2'd0, cm(32'h8), I, S_IDLE, "os_ctrl_en_cleared");
        tick();
        ch(2'd2, 0, I, "os_irq_hold");
        wr(2'd1, 0);
        ch(2'd1, 0, 1'b0, "os_irq_cleared");

        // auto-reload, PRESET=3, CTRL=0xB: period of 6 edges
        wr(2'd1, 3);
        wr(2'd0, 32'hB);
        for (int k = 0; k < 11; k++) begin
            if (k > 0) tick();
            chs(2'd2, ar_cnt[k], (ar_st[k] == S_INT) ? I : 1'b0, ar_st[k], $sformatf("ar_step%0d", k));
        end
        ch(2'd0, cm(32'hB), I, "ar_ctrl_kept");
        wr(2'd0, 32'h0);
        chs(2'd0, 0, 1'b0, S_IDLE, "ar_stop");

        // pause mid-count, PRESET=10
        wr(2'd1, 10);
        wr(2'd0, 32'h9);
        for (int k = 0; k < 5; k++) begin
            tick();
            chs(2'd2, 10 - k, 1'b0, S_CNT, $sformatf("pz_cnt%0d", 10 - k));
        end
        wr(2'd0, 32'h8);
        chs(2'd2, 5, 1'b0, S_CNT, "pz_commit_dec");
        tick();
        chs(2'd2, 5, 1'b0, S_IDLE, "pz_idle");
        tick();
        ch(2'd2, 5, 1'b0, "pz_hold");
        ch(2'd0, cm(32'h8), 1'b0, "pz_ctrl");
        wr(2'd0, 32'h9);
        chs(2'd2, 5, 1'b0, S_LOAD, "pz_reenable_load");
        tick();
        chs(2'd2, 10, 1'b0, S_CNT, "pz_reload10");

        // asynchronous reset mid-count at COUNT=7
        tick();
        tick();
        tick();
        chs(2'd2, 7, 1'b0, S_CNT, "mr_cnt7");
        reset = 1'b1;
        #1;
        chs(2'd0, 0, 1'b0, S_IDLE, "mr_ctrl");
        ch(2'd1, 0, 1'b0, "mr_preset");
        ch(2'd2, 0, 1'b0, "mr_count");
        ch(2'd3, 0, 1'b0, "mr_rsvd");
        reset = 1'b0;
        tick();
        tick();
        chs(2'd2, 0, 1'b0, S_IDLE, "mr_stays_idle");

        // bus decode with COUNT frozen at 2
        wr(2'd1, 4);
        wr(2'd0, 32'h1);
        tick();
        tick();
        wr(2'd0, 32'h0);
        tick();
        chs(2'd2, 2, 1'b0, S_IDLE, "dec_frozen");
        wr(2'd2, 32'h1234);
        ch(2'd2, 2, 1'b0, "dec_count_ro");
        wr(2'd3, 32'h1234);
        ch(2'd2, 2, 1'b0, "dec_rsvd_wr");
        ch(2'd3, 0, 1'b0, "dec_rsvd_rd");
        wr(2'd0, 32'hFFFF_FFFF);
        ch(2'd0, cm(32'hF), 1'b0, "dec_ctrl_mask");
        ch(2'd1, 4, 1'b0, "dec_preset");

        #5;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL leftover: %0d expectations unconsumed, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
